red_pitaya_asg_bank_sched: RTL
==============================

// Module: red_pitaya_asg_bank_sched
// PURPOSE
//  Ping-pong scheduler for one double-buffered ASG channel.
//  - Software writes the inactive parameter/waveform bank, then commits it.
//  - On each end-of-bank event the scheduler swaps the active bank, resets the channel FSM and re-triggers it.
//  - Sits between the bus register block and the channel: drives the channel's bank select, set_rst and software trigger.
// PARAMETERS
//  CNTW     16  width of the swap counter
//  RST_CYC  2   cycles ch_rst_o is held high before each (re)trigger; legal range 1..15
// PORTS
//  dac_clk_i       in   1     DAC clock; the only clock
//  dac_rst_i       in   1     synchronous reset, active high
//  start_i         in   1     pulse: begin playback
//  stop_i          in   1     pulse: abort playback, return to IDLE
//  loop_i          in   1     level: replay the current bank if no commit is pending at end-of-bank
//  sw_commit_i     in   1     pulse: the inactive bank is fully written
//  underrun_clr_i  in   1     pulse: clear underrun_o
//  ch_done_i       in   1     pulse from the channel: active bank finished (its trig_done)
//  sw_bank_o       out  1     bank software may write; always ~ch_bank_o
//  pending_o       out  1     a committed bank is waiting to be played
//  ch_bank_o       out  1     active bank select to the channel
//  ch_rst_o        out  1     channel FSM reset (set_rst)
//  ch_trig_o       out  1     one-cycle software trigger to the channel
//  underrun_o      out  1     sticky: end-of-bank with nothing pending and loop_i low
//  swap_cnt_o      out  CNTW  number of bank swaps since reset
//  state_o         out  2     current FSM state, for status readback
// BEHAVIOUR
//  Reset values: ch_bank_o=0, sw_bank_o=1, pending_o=0, ch_rst_o=1, ch_trig_o=0, underrun_o=0, swap_cnt_o=0, state=IDLE.
//  Effective commit: pend_eff = pending_o | sw_commit_i. A commit in the same cycle as a swap decision counts toward that decision.
//  States (2-bit encoding) and transitions; stop_i takes priority over everything except reset:
//  - IDLE (0): ch_rst_o=1. ch_done_i is ignored.
//    - start_i & pend_eff: swap, -> RST.
//    - start_i & !pend_eff & loaded: -> RST with the same bank. "loaded" means at least one commit has been consumed since reset.
//    - start_i otherwise: ignored.
//  - RST (1): ch_rst_o=1 for exactly RST_CYC cycles (down-counter), then -> TRIG.
//  - TRIG (2): ch_rst_o=0, ch_trig_o=1 for this single cycle, -> RUN.
//  - RUN (3): ch_rst_o=0.
//    - On ch_done_i & pend_eff: swap, -> RST.
//    - On ch_done_i & !pend_eff & loop_i: -> RST, same bank.
//    - On ch_done_i & !pend_eff & !loop_i: set underrun_o, -> IDLE.
//  - stop_i in any state: -> IDLE next cycle, ch_rst_o=1. A pending commit is kept.
//  Swap (single cycle, registered):
//  - ch_bank_o <= ~ch_bank_o; pending_o <= 0.
//  - swap_cnt_o <= swap_cnt_o + 1, wrapping modulo 2^CNTW.
//  - sw_bank_o follows combinationally as ~ch_bank_o.
//  Commit outside a swap: pending_o <= 1. A second commit while pending is legal; the bank is simply re-armed, no error.
//  Latency: ch_done_i -> ch_bank_o change 1 cycle; ch_trig_o high RST_CYC+1 cycles after the swap edge.
//  underrun_clr_i clears underrun_o. If clear and set coincide, set wins.
//  dac_rst_i mid-operation: all state returns to reset values next edge; ch_rst_o holds the channel in reset throughout.
// STRUCTURE
//  Shared package asg_pkg:
//  - localparams ASG_ST_IDLE/RST/TRIG/RUN (2-bit).
//  - ASG_BANK0/ASG_BANK1 constants.
//  Single flat module, no sub-modules. The RST_CYC down-counter is ceil(log2(RST_CYC+1)) bits wide.
// TESTING
//  1. Reset, commit, start -> ch_bank_o=1, swap_cnt_o=1, ch_rst_o high 2 cycles, ch_trig_o pulse at cycle 4 after start.
//  2. RUN, commit, then ch_done_i -> ch_bank_o toggles to 0, pending_o=0, swap_cnt_o=2, one ch_trig_o pulse follows.
//  3. RUN, no commit, loop_i=1, ch_done_i -> same bank retriggered, swap_cnt_o unchanged, underrun_o=0.
//  4. RUN, no commit, loop_i=0, ch_done_i -> underrun_o=1, state IDLE; underrun_clr_i -> 0; set/clear same cycle -> 1.
//  5. sw_commit_i and ch_done_i in the same cycle -> swap occurs, pending_o=0; stop_i with ch_done_i -> IDLE, no swap.
//  6. swap_cnt_o forced to 16'hFFFF, then swap -> 16'h0000; dac_rst_i during RST -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/asg_pkg.sv
// Shared constants for the double-buffered ASG channel scheduler.
// State encodings are exposed on state_o for status readback.
package asg_pkg;

    localparam logic [1:0] ASG_ST_IDLE = 2'd0;
    localparam logic [1:0] ASG_ST_RST  = 2'd1;
    localparam logic [1:0] ASG_ST_TRIG = 2'd2;
    localparam logic [1:0] ASG_ST_RUN  = 2'd3;

    localparam logic ASG_BANK0 = 1'b0;
    localparam logic ASG_BANK1 = 1'b1;

endpackage

// File: rtl/red_pitaya_asg_bank_sched.sv
// Ping-pong bank scheduler for one double-buffered ASG channel:
// swaps banks at end-of-bank, then resets and re-triggers the channel.
module red_pitaya_asg_bank_sched
    import asg_pkg::*;
#(
    parameter int CNTW    = 16,
    parameter int RST_CYC = 2
) (
    input  logic            dac_clk_i,
    input  logic            dac_rst_i,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic            loop_i,
    input  logic            sw_commit_i,
    input  logic            underrun_clr_i,
    input  logic            ch_done_i,
    output logic            sw_bank_o,
    output logic            pending_o,
    output logic            ch_bank_o,
    output logic            ch_rst_o,
    output logic            ch_trig_o,
    output logic            underrun_o,
    output logic [CNTW-1:0] swap_cnt_o,
    output logic [1:0]      state_o
);

    localparam int CW = $clog2(RST_CYC + 1);

    logic [1:0]      state_q, state_d;
    logic            bank_q, bank_d;
    logic            pending_q, pending_d;
    logic            underrun_q, underrun_d;
    logic            loaded_q, loaded_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CNTW-1:0] swap_cnt_q, swap_cnt_d;

    logic pend_eff;
    logic swap;
    logic rearm;
    logic set_under;

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q    <= ASG_ST_IDLE;
            bank_q     <= ASG_BANK0;
            pending_q  <= 1'b0;
            underrun_q <= 1'b0;
            loaded_q   <= 1'b0;
            cnt_q      <= '0;
            swap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            pending_q  <= pending_d;
            underrun_q <= underrun_d;
            loaded_q   <= loaded_d;
            cnt_q      <= cnt_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    // A commit arriving with the swap decision is consumed by that swap.
    always_comb begin
        pend_eff  = pending_q | sw_commit_i;
        swap      = 1'b0;
        rearm     = 1'b0;
        set_under = 1'b0;
        state_d   = state_q;
        if (stop_i) begin
            state_d = ASG_ST_IDLE;
        end else begin
            unique case (state_q)
                ASG_ST_IDLE: begin
                    if (start_i && pend_eff) swap = 1'b1;
                    else if (start_i && loaded_q) rearm = 1'b1;
                end
                ASG_ST_RST: begin
                    if (cnt_q == CW'(1)) state_d = ASG_ST_TRIG;
                end
                ASG_ST_TRIG: state_d = ASG_ST_RUN;
                ASG_ST_RUN: begin
                    if (ch_done_i) begin
                        if (pend_eff) swap = 1'b1;
                        else if (loop_i) rearm = 1'b1;
                        else begin
                            set_under = 1'b1;
                            state_d   = ASG_ST_IDLE;
                        end
                    end
                end
            endcase
        end
        if (swap || rearm) state_d = ASG_ST_RST;
    end

    always_comb begin
        bank_d     = bank_q ^ swap;
        pending_d  = swap ? 1'b0 : pend_eff;
        swap_cnt_d = swap_cnt_q + CNTW'(swap);
        loaded_d   = loaded_q | swap;
        underrun_d = set_under | (underrun_q & ~underrun_clr_i);
        cnt_d      = cnt_q;
        if (swap || rearm) cnt_d = CW'(RST_CYC);
        else if (state_q == ASG_ST_RST) cnt_d = cnt_q - CW'(1);
    end

    always_comb begin
        ch_rst_o   = (state_q == ASG_ST_IDLE) || (state_q == ASG_ST_RST);
        ch_trig_o  = (state_q == ASG_ST_TRIG);
        ch_bank_o  = bank_q;
        sw_bank_o  = ~bank_q;
        pending_o  = pending_q;
        underrun_o = underrun_q;
        swap_cnt_o = swap_cnt_q;
        state_o    = state_q;
    end

endmodule
